// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side checker for the on-chip 8-bit LFSR generator
// (taps 7,5,4,3; next = {s[6:0], s[7]^s[5]^s[4]^s[3]}).
// It hunts for a nonzero seed, verifies LOCK_COUNT consecutive predicted
// samples, then flywheels on its own prediction and flags/counts mismatches.
// LOSS_COUNT consecutive mismatches while locked drop back to hunting.
//
// Build option:
//   LFSR_CHECKER_BITERR_EN  - when defined, err_count accumulates the number of
//                             differing bits per mismatched sample instead of
//                             one per mismatched sample.
// -----------------------------------------------------------------------------
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       clear,
    output logic       locked,
    output logic       err_flag,
    output logic [7:0] err_count,
    output logic [1:0] state_o
);

    // FSM encoding; value 3 is unreachable and recovers to HUNT.
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT_C = 4'(LOSS_COUNT);

    // One step of the generator polynomial.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        lfsr_step = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        popcount8 = cnt;
    endfunction

    // Add a small increment to the error counter, pinning at 0xFF.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {5'b00000, b};
        sat_add8 = sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // State registers
    logic [1:0] state_q,     state_d;
    logic [7:0] exp_q,       exp_d;
    logic [3:0] match_q,     match_d;
    logic [3:0] miss_q,      miss_d;
    logic       locked_q,    locked_d;
    logic       err_flag_q,  err_flag_d;
    logic [7:0] err_count_q, err_count_d;

    // Combinational helpers
    logic [7:0] pred_s;
    logic       match_s;
    logic [3:0] match_inc_s;
    logic [3:0] miss_inc_s;
    logic       err_event_s;
    logic [3:0] err_inc_s;

    assign pred_s      = lfsr_step(exp_q);
    assign match_s     = (data_in == pred_s);
    assign match_inc_s = match_q + 4'd1;
    assign miss_inc_s  = miss_q + 4'd1;

    // Error weight per mismatched sample: bit errors or word errors.
    always_comb begin
`ifdef LFSR_CHECKER_BITERR_EN
        err_inc_s = popcount8(data_in ^ pred_s);
`else
        err_inc_s = 4'd1;
`endif
    end

    // Hunt / verify / locked sequencing and predictor update.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_event_s = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (data_valid && (data_in != 8'h00)) begin
                    // Any nonzero byte is a legal LFSR state: take it as seed.
                    exp_d   = data_in;
                    match_d = 4'd0;
                    state_d = ST_VERIFY;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_VERIFY: begin
                if (data_valid) begin
                    if (match_s) begin
                        exp_d   = data_in;
                        match_d = match_inc_s;
                        if (match_inc_s == LOCK_CNT_C) begin
                            state_d = ST_LOCKED;
                            miss_d  = 4'd0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        match_d = 4'd0;
                        if (data_in != 8'h00) begin
                            // Reseed from the received byte and keep verifying.
                            exp_d   = data_in;
                            state_d = ST_VERIFY;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end else begin
                    state_d = ST_VERIFY;
                end
            end
            ST_LOCKED: begin
                if (data_valid) begin
                    // Flywheel: once locked, received data never reseeds.
                    exp_d = pred_s;
                    if (match_s) begin
                        miss_d  = 4'd0;
                        state_d = ST_LOCKED;
                    end else begin
                        err_event_s = 1'b1;
                        miss_d      = miss_inc_s;
                        if (miss_inc_s == LOSS_CNT_C) begin
                            state_d = ST_HUNT;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // Output next-state: flag pulse, saturating counter with clear priority.
    always_comb begin
        err_flag_d = err_event_s;
        locked_d   = (state_d == ST_LOCKED);
        if (clear) begin
            err_count_d = 8'h00;
        end else if (err_event_s) begin
            err_count_d = sat_add8(err_count_q, err_inc_s);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Register all state and outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            exp_q       <= 8'h00;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            locked_q    <= 1'b0;
            err_flag_q  <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// Testbench for lfsr_checker (LOCK_COUNT=4, LOSS_COUNT=3).
// Directed vector table, hand-written multi-cycle sequences and a randomized
// generator stream compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;

`ifdef LFSR_CHECKER_BITERR_EN
    localparam bit BITERR = 1'b1;
`else
    localparam bit BITERR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       clear;
    logic       locked;
    logic       err_flag;
    logic [7:0] err_count;
    logic [1:0] state_o;

    lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .clear     (clear),
        .locked    (locked),
        .err_flag  (err_flag),
        .err_count (err_count),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 hunting, 1 verifying, 2 locked
    int         m_mode;
    logic [7:0] m_exp;
    int         m_run;
    int         m_miss;
    int         m_cnt;
    bit         m_flag;

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        int v;
        v = (int'(s) * 2) % 256 + ($countones(s & 8'hB8) % 2);
        return 8'(v);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_exp = 8'h00; m_run = 0; m_miss = 0; m_cnt = 0; m_flag = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit c);
        logic [7:0] p;
        int add;
        add    = 0;
        m_flag = 1'b0;
        p      = ref_next(m_exp);
        if (v) begin
            if (m_mode == 0) begin
                if (d != 8'h00) begin m_exp = d; m_run = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == p) begin
                    m_exp = d; m_run++;
                    if (m_run == LOCK_N) begin m_mode = 2; m_miss = 0; end
                end else begin
                    m_run = 0;
                    if (d != 8'h00) m_exp = d; else m_mode = 0;
                end
            end else begin
                m_exp = p;
                if (d == p) m_miss = 0;
                else begin
                    m_flag = 1'b1;
                    add = BITERR ? $countones(d ^ p) : 1;
                    m_miss++;
                    if (m_miss == LOSS_N) m_mode = 0;
                end
            end
        end
        if (c) m_cnt = 0;
        else   m_cnt = (m_cnt + add > 255) ? 255 : m_cnt + add;
    endtask

    // Drive one cycle, sample #1 after the edge, advance model.
    task automatic cycle(input bit v, input logic [7:0] d, input bit c);
        data_valid = v; data_in = d; clear = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".locked"},    8'(locked),    8'(m_mode == 2));
        chk({tag, ".err_flag"},  8'(err_flag),  8'(m_flag));
        chk({tag, ".err_count"}, err_count,     8'(m_cnt));
        chk({tag, ".state"},     8'(state_o),   8'(m_mode));
    endtask

    task automatic mcycle(input string tag, input bit v, input logic [7:0] d, input bit c);
        cycle(v, d, c);
        cmp_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; data_valid = 1'b0; data_in = 8'h00; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic lock_seq(input string tag);
        mcycle(tag, 1'b1, 8'hFF, 1'b0);
        mcycle(tag, 1'b1, 8'hFE, 1'b0);
        mcycle(tag, 1'b1, 8'hFC, 1'b0);
        mcycle(tag, 1'b1, 8'hF8, 1'b0);
        mcycle(tag, 1'b1, 8'hF0, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         c;
        bit         lk;
        bit         fl;
        logic [7:0] cnt;
        logic [1:0] st;
    } vec_t;

    localparam logic [7:0] E1 = BITERR ? 8'd8  : 8'd1;
    localparam logic [7:0] L1 = BITERR ? 8'd3  : 8'd1;
    localparam logic [7:0] L2 = BITERR ? 8'd8  : 8'd2;
    localparam logic [7:0] L3 = BITERR ? 8'd10 : 8'd3;

    vec_t tbl[17];

    function automatic vec_t mk(bit v, logic [7:0] d, bit c, bit lk, bit fl,
                                logic [7:0] cnt, logic [1:0] st);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.lk = lk; r.fl = fl; r.cnt = cnt; r.st = st;
        return r;
    endfunction

    initial begin
        logic [7:0] g;
        logic [7:0] p;
        bit         v;
        bit         c;
        logic [7:0] d;
        int         r;

        //            v     d      clr   lk    fl    cnt    st
        tbl[0]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0); // zero ignored in HUNT
        tbl[1]  = mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1); // seed
        tbl[2]  = mk(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1);
        tbl[3]  = mk(1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1);
        tbl[4]  = mk(1'b1, 8'hF8, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1);
        tbl[5]  = mk(1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1); // idle cycle
        tbl[6]  = mk(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2); // lock
        tbl[7]  = mk(1'b1, 8'h1E, 1'b0, 1'b1, 1'b1, E1,    2'd2); // single error (exp E1)
        tbl[8]  = mk(1'b1, 8'hC2, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2); // match + clear
        tbl[9]  = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, L1,    2'd2); // exp 85
        tbl[10] = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, L2,    2'd2); // exp 0B
        tbl[11] = mk(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, L3,    2'd0); // exp 17 -> loss
        tbl[12] = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, L3,    2'd1); // new seed
        tbl[13] = mk(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, L3,    2'd1); // wrong nonzero -> reseed
        tbl[14] = mk(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, L3,    2'd1); // follows reseed 77
        tbl[15] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, L3,    2'd0); // zero -> HUNT
        tbl[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0); // clear while idle

        do_reset();
        chk("reset.locked",    8'(locked),   8'h00);
        chk("reset.err_flag",  8'(err_flag), 8'h00);
        chk("reset.err_count", err_count,    8'h00);
        chk("reset.state",     8'(state_o),  8'h00);

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d.locked", i),    8'(locked),   8'(tbl[i].lk));
            chk($sformatf("vec%0d.err_flag", i),  8'(err_flag), 8'(tbl[i].fl));
            chk($sformatf("vec%0d.err_count", i), err_count,    tbl[i].cnt);
            chk($sformatf("vec%0d.state", i),     8'(state_o),  8'(tbl[i].st));
        end

        // ---------------- saturation and clear priority ----------------
        do_reset();
        lock_seq("sat_lock");
        for (int i = 0; i < 300; i++) begin
            p = ref_next(m_exp);
            mcycle("sat_err", 1'b1, ~p, 1'b0);
            p = ref_next(m_exp);
            mcycle("sat_ok", 1'b1, p, 1'b0);
        end
        chk("sat.hold_ff", err_count, 8'hFF);
        chk("sat.still_locked", 8'(locked), 8'h01);
        p = ref_next(m_exp);
        cycle(1'b1, ~p, 1'b1);
        chk("clr_err.err_count", err_count, 8'h00);
        chk("clr_err.err_flag", 8'(err_flag), 8'h01);

        // ---------------- reset mid-lock ----------------
        do_reset();
        lock_seq("rml_lock");
        for (int i = 0; i < 5; i++) begin
            p = ref_next(m_exp);
            mcycle("rml_err", 1'b1, ~p, 1'b0);
            p = ref_next(m_exp);
            mcycle("rml_ok", 1'b1, p, 1'b0);
        end
        chk("rml.count5", err_count, BITERR ? 8'd40 : 8'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rml.async_locked",    8'(locked),   8'h00);
        chk("rml.async_err_flag",  8'(err_flag), 8'h00);
        chk("rml.async_err_count", err_count,    8'h00);
        chk("rml.async_state",     8'(state_o),  8'h00);
        #1;
        rst_n = 1'b1;
        model_reset();
        mcycle("relock", 1'b1, 8'hFF, 1'b0);
        mcycle("relock", 1'b1, 8'hFE, 1'b0);
        mcycle("relock", 1'b1, 8'hFC, 1'b0);
        mcycle("relock", 1'b1, 8'hF8, 1'b0);
        chk("relock.not_yet", 8'(locked), 8'h00);
        mcycle("relock", 1'b1, 8'hF0, 1'b0);
        chk("relock.locked", 8'(locked), 8'h01);

        // ---------------- randomized generator stream ----------------
        do_reset();
        g = 8'($urandom_range(1, 255));
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r == 99) g = 8'($urandom_range(1, 255));
            v = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 49) == 0);
            d = g;
            if (r < 4)       d = 8'($urandom_range(0, 255));
            else if (r < 6)  d = 8'h00;
            else if (r < 10) d = g ^ 8'($urandom_range(1, 255));
            mcycle("rand", v, d, c);
            if (v) g = ref_next(g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the on-chip 8-bit LFSR random generator. Consumes the byte stream the generator produces (polynomial taps 7,5,4,3; next state = {s[6:0], s[7]^s[5]^s[4]^s[3]}; one LFSR step per valid sample) and self-synchronises to it. Once locked, it flags and counts mismatches, giving a loopback/bring-up checker for the generator pins.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive predicted matches needed to declare lock (1..15)
- LOSS_COUNT, 3: consecutive mismatches while locked that drop lock (1..15)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- data_in  input  8  received generator byte
- data_valid  input  1  data_in sampled on this edge; each valid = one LFSR step
- clear  input  1  synchronous clear of err_count
- locked  output  1  high while in LOCKED state
- err_flag  output  1  one-cycle pulse per mismatched sample in LOCKED
- err_count  output  8  saturating error counter
- state_o  output  2  current FSM state (HUNT=0, VERIFY=1, LOCKED=2)

## Operation
- Internal: exp_state[7:0] (last accepted/predicted LFSR state), match_cnt[3:0], miss_cnt[3:0]. pred = step(exp_state).
- All outputs registered. Cycles with data_valid=0 change nothing except clear handling.
- HUNT: data_in==0x00 ignored (illegal LFSR state), stay HUNT. Otherwise exp_state<=data_in, match_cnt<=0, go VERIFY.
- VERIFY: data_in==pred: exp_state<=data_in, match_cnt+1; when the incremented count equals LOCK_COUNT go LOCKED, miss_cnt<=0. Mismatch: match_cnt<=0; if data_in!=0 reseed exp_state<=data_in and stay VERIFY, else go HUNT. No errors counted outside LOCKED.
- LOCKED: exp_state<=pred always (flywheel; received data never reseeds). Match: miss_cnt<=0. Mismatch: err_flag pulse, err_count increment, miss_cnt+1; when incremented miss_cnt equals LOSS_COUNT go HUNT (the error causing loss is still counted).
- err_count saturates at 0xFF; never wraps.
- clear=1: err_count<=0 that edge; clear wins over a same-cycle error (that error is dropped from the count, err_flag still pulses). clear does not affect FSM, locked or exp_state.
- 2-state 'state_o=3' unreachable; if ever entered, next edge goes HUNT.

## Timing
- Reset (rst_n low, asynchronous): state HUNT, exp_state=0x00, match_cnt=0, miss_cnt=0, locked=0, err_flag=0, err_count=0x00, state_o=0.
- Latency: a sample on edge N is reflected in locked/err_flag/err_count/state_o immediately after edge N (1-cycle registered).
- Lock acquisition: minimum 1+LOCK_COUNT valid samples; locked rises after the edge of the last matching sample.
- err_flag high exactly one cycle per mismatch; back-to-back mismatches give consecutive high cycles.
- Reset mid-operation: immediate return to reset values; first valid sample after rst_n release is treated as a HUNT seed.

## Configuration
- LFSR_CHECKER_BITERR_EN defined: err_count increments by popcount(data_in ^ pred) per mismatched sample (1..8), saturating at 0xFF.
- Not defined: err_count increments by 1 per mismatched sample (word error count). err_flag and FSM behaviour identical in both builds.

## Test plan
- Lock: reset, feed valid FF,FE,FC,F8,F0 (LOCK_COUNT=4) -> state_o 0->1 after FF, locked=1 after F0 edge, err_count=0x00.
- Single error: after lock, feed 1E instead of expected E1, then C2 -> err_flag one cycle, err_count=1 (=8 with LFSR_CHECKER_BITERR_EN), locked stays 1, C2 accepted as match.
- Loss of lock: after lock, feed three 0x55 samples (LOSS_COUNT=3) -> three err_flag pulses, err_count=3, locked=0 and state_o=0 after third.
- Zero/reseed: in HUNT feed 0x00 -> stay HUNT; in VERIFY feed wrong nonzero byte -> stay VERIFY with new seed; feed 0x00 -> HUNT.
- Clear/saturation: force 300 word errors (re-locking as needed) -> err_count holds 0xFF; assert clear in same cycle as a mismatch -> err_count=0x00, err_flag=1.
- Reset mid-lock: while locked with err_count=5, pulse rst_n low between edges -> all outputs zero immediately, relock needs full sequence.
